// File: rtl/fpu_div_serdes.sv
// ---------------------------------------------------------------------------
// fpu_div_serdes
// Bit-serial wrapper around a combinational single-precision divider.
// Shifts rs1/rs2 in LSB-first and holds them on o_a/o_b. After a fixed
// settle time it captures the divider quotient from i_q and shifts it back
// out LSB-first on o_rd. It also reports the IEEE invalid-operation and
// divide-by-zero flags for the captured operands.
// ---------------------------------------------------------------------------
module fpu_div_serdes #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_rs1,
    input  logic        i_rs2,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    input  logic [31:0] i_q,
    output logic        o_rd,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_nv,
    output logic        o_dz
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_SHIFT  = 3'd4;

    // Counter value on the last settle cycle. It is unused when there is no
    // settle phase, so that case is clamped to 0 to avoid an underflow.
    localparam logic [4:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 5'd0 : 5'(SETTLE_CYCLES - 1);

    localparam logic [4:0] BIT_LAST = 5'd31;

    // State and datapath registers
    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic        r_nv;
    logic        r_dz;

    // Combinational helpers
    logic [2:0]  w_state_nxt;
    logic        w_accept;
    logic        w_load_shift;
    logic        w_latch;
    logic        w_res_shift;

    // Operand classification
    logic [7:0]  w_a_exp;
    logic [7:0]  w_b_exp;
    logic [22:0] w_a_man;
    logic [22:0] w_b_man;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_snan;
    logic        w_b_snan;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_nv;
    logic        w_dz;

    // An abort in IDLE beats a simultaneous start, so nothing launches.
    assign w_accept     = (r_state == ST_IDLE) && i_start && !i_abort;
    // Bit 0 enters on the accepting edge and bits 1..31 enter while in LOAD.
    // An abort freezes the operand registers where they are.
    assign w_load_shift = w_accept || ((r_state == ST_LOAD) && !i_abort);
    assign w_latch      = (r_state == ST_LATCH) && !i_abort;
    assign w_res_shift  = (r_state == ST_SHIFT) && !i_abort;

    // Next-state selection; an abort from any active state returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == BIT_LAST) begin
                    w_state_nxt = (SETTLE_CYCLES == 0) ? ST_LATCH : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_nxt = i_abort ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_abort || (r_cnt == BIT_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared counter: input bits in LOAD, settle cycles, then output bits.
    // The accepting edge already consumes bit 0, so the count starts at 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            r_cnt <= 5'd1;
        end else begin
            case (r_state)
                ST_LOAD:   r_cnt <= r_cnt + 5'd1;
                ST_SETTLE: r_cnt <= (r_cnt == SETTLE_LAST) ? 5'd0 : r_cnt + 5'd1;
                ST_LATCH:  r_cnt <= 5'd0;
                ST_SHIFT:  r_cnt <= r_cnt + 5'd1;
                default:   r_cnt <= r_cnt;
            endcase
        end
    end

    // Operand deserialisers: new bits enter at the MSB, so the first bit
    // received ends up in bit 0 after 32 shifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= 32'd0;
            r_b <= 32'd0;
        end else if (w_load_shift) begin
            r_a <= {i_rs1, r_a[31:1]};
            r_b <= {i_rs2, r_b[31:1]};
        end
    end

    // Result shift register: capture the quotient, then shift it out LSB-first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res <= 32'd0;
        end else if (w_latch) begin
            r_res <= i_q;
        end else if (w_res_shift) begin
            r_res <= {1'b0, r_res[31:1]};
        end
    end

    // Split the held operands into IEEE-754 fields
    assign w_a_exp  = r_a[30:23];
    assign w_b_exp  = r_b[30:23];
    assign w_a_man  = r_a[22:0];
    assign w_b_man  = r_b[22:0];

    // A signalling NaN is a NaN whose quiet bit (the mantissa MSB) is clear
    assign w_a_nan  = (w_a_exp == 8'hFF) && (w_a_man != 23'd0);
    assign w_b_nan  = (w_b_exp == 8'hFF) && (w_b_man != 23'd0);
    assign w_a_snan = w_a_nan && !w_a_man[22];
    assign w_b_snan = w_b_nan && !w_b_man[22];
    assign w_a_inf  = (w_a_exp == 8'hFF) && (w_a_man == 23'd0);
    assign w_b_inf  = (w_b_exp == 8'hFF) && (w_b_man == 23'd0);
    assign w_a_zero = (w_a_exp == 8'h00) && (w_a_man == 23'd0);
    assign w_b_zero = (w_b_exp == 8'h00) && (w_b_man == 23'd0);

    // 0/0 and Inf/Inf are invalid. x/0 raises DZ only for a finite non-zero x.
    assign w_nv = w_a_snan || w_b_snan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
    assign w_dz = w_b_zero && !w_a_zero && !w_a_nan && !w_a_inf;

    // Exception flags: cleared at launch, set at capture, held otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nv <= 1'b0;
            r_dz <= 1'b0;
        end else if (w_accept) begin
            r_nv <= 1'b0;
            r_dz <= 1'b0;
        end else if (w_latch) begin
            r_nv <= w_nv;
            r_dz <= w_dz;
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_nv       = r_nv;
    assign o_dz       = r_dz;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_rd_valid = (r_state == ST_SHIFT);
    // Gate o_rd so stale result bits left by an abort never leak out while idle
    assign o_rd       = (r_state == ST_SHIFT) && r_res[0];
    // An abort on the final bit suppresses the completion pulse
    assign o_done     = (r_state == ST_SHIFT) && (r_cnt == BIT_LAST) && !i_abort;

endmodule
